// File: rtl/bus_pkg.sv
// Shared definitions for the CPU bus arbiter.
//   - NUM_SRC   : number of bus sources (select codes 0..24)
//   - IDLE_SEL  : unused select code; the 32:1 bus multiplexer drives zero on it
//   - bus_src_e : symbolic select codes of every bus source
//   - arb_state_e : arbiter FSM states
//   - src_onehot(): converts a select code into a one-hot grant vector
package bus_pkg;

    localparam int NUM_SRC = 25;
    localparam logic [4:0] IDLE_SEL = 5'b11111;

    typedef enum logic [4:0] {
        SRC_R0  = 5'd0,
        SRC_R1  = 5'd1,
        SRC_R2  = 5'd2,
        SRC_R3  = 5'd3,
        SRC_R4  = 5'd4,
        SRC_R5  = 5'd5,
        SRC_R6  = 5'd6,
        SRC_R7  = 5'd7,
        SRC_R8  = 5'd8,
        SRC_R9  = 5'd9,
        SRC_R10 = 5'd10,
        SRC_R11 = 5'd11,
        SRC_R12 = 5'd12,
        SRC_R13 = 5'd13,
        SRC_R14 = 5'd14,
        SRC_R15 = 5'd15,
        SRC_HI  = 5'd16,
        SRC_LO  = 5'd17,
        SRC_ZHI = 5'd18,
        SRC_ZLO = 5'd19,
        SRC_PC  = 5'd20,
        SRC_MDR = 5'd21,
        SRC_MAR = 5'd22,
        SRC_PORT = 5'd23,
        SRC_C   = 5'd24
    } bus_src_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Codes outside 0..24 (including IDLE_SEL) map to an all-zero vector.
    function automatic logic [NUM_SRC-1:0] src_onehot(input logic [4:0] code);
        logic [NUM_SRC-1:0] vec;
        vec = '0;
        if (code < 5'(NUM_SRC)) begin
            vec[code] = 1'b1;
        end
        return vec;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin winner selection for the bus arbiter (purely combinational).
// Ports:
//   req        [24:0] in  : per-source request vector
//   last_owner [4:0]  in  : code of the most recent owner; search starts one above it
//   winner     [4:0]  out : first requesting code found, ascending with wrap 24 -> 0
//   any               out : high when at least one request bit is set
module rr_picker
    import bus_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [4:0]         last_owner,
    output logic [4:0]         winner,
    output logic               any
);

    int idx;

    // Walk all 25 codes starting just after last_owner; the last step lands on
    // last_owner itself, so a lone requester that just owned the bus can win again.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(last_owner) + k) % NUM_SRC;
            if (!any && req[idx]) begin
                winner = 5'(idx);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the 25-source CPU bus.
// A two-state FSM (IDLE/GRANT) hands the bus to one source at a time. Every
// ownership ends on release, on the owner dropping its request, or after
// MAX_HOLD cycles, and is always followed by one IDLE turnaround cycle.
// Parameters:
//   MAX_HOLD : longest uninterrupted ownership in cycles (1..255)
// Ports:
//   clock             in  : system clock, rising edge
//   clear             in  : asynchronous active-high reset
//   req        [24:0] in  : per-source request, bit i = select code i
//   release_bus       in  : owner finished (named so because 'release' is a
//                           reserved word); only looked at while granting
//   grant      [24:0] out : registered one-hot grant, zero when idle
//   bus_select [4:0]  out : registered multiplexer select, 31 when idle
//   bus_valid         out : registered, high while a source owns the bus
//   timeout           out : one-cycle pulse after a MAX_HOLD-forced exit
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic               clock,
    input  logic               clear,
    input  logic [NUM_SRC-1:0] req,
    input  logic               release_bus,
    output logic [NUM_SRC-1:0] grant,
    output logic [4:0]         bus_select,
    output logic               bus_valid,
    output logic               timeout
);

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    arb_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [4:0]         bus_select_q, bus_select_d;
    logic               bus_valid_q, bus_valid_d;
    logic               timeout_q, timeout_d;
    logic [7:0]         hold_cnt_q, hold_cnt_d;
    logic [4:0]         last_owner_q, last_owner_d;

    logic [4:0] pick_winner;
    logic       pick_any;
    logic [7:0] hold_next;
    logic       at_limit;
    logic       owner_req;
    logic       end_own;

    rr_picker u_picker (
        .req        (req),
        .last_owner (last_owner_q),
        .winner     (pick_winner),
        .any        (pick_any)
    );

    // The counter is cleared on entry, so hold_next equals the number of
    // cycles owned including the current one; hitting the limit here means
    // the owner has had exactly MAX_HOLD cycles.
    assign hold_next = hold_cnt_q + 8'd1;
    assign at_limit  = (hold_next == HOLD_LIMIT);
    assign owner_req = req[last_owner_q];
    assign end_own   = release_bus | ~owner_req | at_limit;

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        bus_select_d = bus_select_q;
        bus_valid_d  = bus_valid_q;
        timeout_d    = 1'b0;
        hold_cnt_d   = hold_cnt_q;
        last_owner_d = last_owner_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d      = ST_GRANT;
                    grant_d      = src_onehot(pick_winner);
                    bus_select_d = pick_winner;
                    bus_valid_d  = 1'b1;
                    hold_cnt_d   = '0;
                    last_owner_d = pick_winner;
                end
            end
            ST_GRANT: begin
                if (end_own) begin
                    state_d      = ST_IDLE;
                    grant_d      = '0;
                    bus_select_d = IDLE_SEL;
                    bus_valid_d  = 1'b0;
                    hold_cnt_d   = '0;
                    // A release coinciding with the hold limit is a normal release.
                    timeout_d    = at_limit & ~release_bus;
                end else begin
                    hold_cnt_d = hold_next;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                grant_d      = '0;
                bus_select_d = IDLE_SEL;
                bus_valid_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; clear drops the grant without waiting for a clock.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            bus_select_q <= IDLE_SEL;
            bus_valid_q  <= 1'b0;
            timeout_q    <= 1'b0;
            hold_cnt_q   <= '0;
            last_owner_q <= SRC_C;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            bus_select_q <= bus_select_d;
            bus_valid_q  <= bus_valid_d;
            timeout_q    <= timeout_d;
            hold_cnt_q   <= hold_cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign grant      = grant_q;
    assign bus_select = bus_select_q;
    assign bus_valid  = bus_valid_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter.
// Stimulus and a behavioural ownership model run in one process and push the
// expected outputs after every clock edge; a monitor pops and compares them
// on the falling edge, and also checks grant shape and ownership length.
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam int HOLD_LIMIT    = 4;
    localparam int RANDOM_CYCLES = 10000;

    logic               clock = 1'b0;
    logic               clear;
    logic [NUM_SRC-1:0] req;
    logic               release_bus;
    logic [NUM_SRC-1:0] grant;
    logic [4:0]         bus_select;
    logic               bus_valid;
    logic               timeout;

    typedef struct {
        logic [NUM_SRC-1:0] grant;
        logic [4:0]         sel;
        logic               valid;
        logic               timeout;
    } expect_t;

    expect_t exp_q[$];
    event    check_now;

    int assert_count = 0;
    int fail_count   = 0;
    int run_len      = 0;

    // Reference model: who owns the bus, for how many cycles, who owned it last.
    int   model_owner   = -1;
    int   model_held    = 0;
    int   model_last    = 24;
    logic model_timeout = 1'b0;

    bus_arbiter #(.MAX_HOLD(HOLD_LIMIT)) dut (
        .clock       (clock),
        .clear       (clear),
        .req         (req),
        .release_bus (release_bus),
        .grant       (grant),
        .bus_select  (bus_select),
        .bus_valid   (bus_valid),
        .timeout     (timeout)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock edge of the ownership rules, applied to the inputs seen at that edge.
    task automatic model_step(input logic [NUM_SRC-1:0] r, input logic rl);
        model_timeout = 1'b0;
        if (model_owner < 0) begin
            for (int k = 1; k <= NUM_SRC; k++) begin
                int c;
                c = (model_last + k) % NUM_SRC;
                if (r[c]) begin
                    model_owner = c;
                    model_last  = c;
                    model_held  = 1;
                    break;
                end
            end
        end else if (rl || !r[model_owner] || model_held >= HOLD_LIMIT) begin
            model_timeout = !rl && (model_held >= HOLD_LIMIT);
            model_owner   = -1;
        end else begin
            model_held++;
        end
    endtask

    function automatic expect_t current_expect();
        expect_t e;
        e.grant   = '0;
        e.sel     = IDLE_SEL;
        e.valid   = 1'b0;
        e.timeout = model_timeout;
        if (model_owner >= 0) begin
            e.grant = 25'd1 << model_owner;
            e.sel   = 5'(model_owner);
            e.valid = 1'b1;
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic [NUM_SRC-1:0] r, input logic rl);
        req         = r;
        release_bus = rl;
        model_step(r, rl);
        @(posedge clock);
        exp_q.push_back(current_expect());
        #1;
    endtask

    // Raise clear halfway between edges and check that outputs drop at once.
    task automatic doReset();
        @(negedge clock);
        #1;
        clear = 1'b1;
        #1;
        model_owner   = -1;
        model_held    = 0;
        model_last    = 24;
        model_timeout = 1'b0;
        exp_q.push_back(current_expect());
        -> check_now;
        @(posedge clock);
        #1;
        clear = 1'b0;
    endtask

    // Monitor: structural checks every sample, then the scoreboard entry if any.
    initial begin
        expect_t e;
        forever begin
            @(negedge clock or check_now);
            if (bus_valid === 1'b1) run_len++;
            else run_len = 0;
            checkOutput("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            if (bus_valid === 1'b1) begin
                checkOutput("grant_at_select", 32'(grant[bus_select]), 32'd1);
                checkOutput("hold_within_max", 32'(run_len <= HOLD_LIMIT), 32'd1);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("grant", 32'(grant), 32'(e.grant));
                checkOutput("bus_select", 32'(bus_select), 32'(e.sel));
                checkOutput("bus_valid", 32'(bus_valid), 32'(e.valid));
                checkOutput("timeout", 32'(timeout), 32'(e.timeout));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NUM_SRC-1:0] r;
        logic [NUM_SRC-1:0] pair;
        clear       = 1'b1;
        req         = '0;
        release_bus = 1'b0;
        doReset();

        // Single request from PC: granted on the following cycle, then dropped.
        applyStimulus(25'd1 << 20, 1'b0);
        applyStimulus('0, 1'b0);
        applyStimulus('0, 1'b0);

        // Sources 3 and MDR alternate; release in IDLE must be ignored.
        doReset();
        pair = (25'd1 << 3) | (25'd1 << 21);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(pair, 1'b1);
            applyStimulus(pair, 1'b0);
            applyStimulus(pair, 1'b1);
        end

        // C held forever: hold limit, timeout pulse, regrant, then release at the limit.
        repeat (6) applyStimulus(25'd1 << 24, 1'b0);
        repeat (3) applyStimulus(25'd1 << 24, 1'b0);
        applyStimulus(25'd1 << 24, 1'b1);
        applyStimulus('0, 1'b0);

        // Owner 5 drops its request without releasing.
        applyStimulus(25'd1 << 5, 1'b0);
        applyStimulus(25'd1 << 5, 1'b0);
        applyStimulus('0, 1'b0);
        applyStimulus('0, 1'b0);

        // Clear during HI ownership, then 0 and HI compete from a fresh start.
        applyStimulus(25'd1 << 16, 1'b0);
        applyStimulus(25'd1 << 16, 1'b0);
        doReset();
        applyStimulus(25'd1 | (25'd1 << 16), 1'b0);
        applyStimulus(25'd1 | (25'd1 << 16), 1'b1);
        applyStimulus(25'd1 | (25'd1 << 16), 1'b0);
        applyStimulus('0, 1'b0);

        // Random traffic with sticky requests so holds and timeouts occur.
        r = '0;
        for (int i = 0; i < RANDOM_CYCLES; i++) begin
            case ($urandom_range(0, 7))
                0: r = 25'($urandom & $urandom);
                1: r = 25'd1 << $urandom_range(0, 24);
                2: r = '0;
                3: r = r ^ (25'd1 << $urandom_range(0, 24));
                default: r = r;
            endcase
            applyStimulus(r, ($urandom_range(0, 5) == 0));
        end

        @(negedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16, maximum consecutive cycles one source may own the bus (range 1-255).
REQ-002 clock  input  1  system clock, all state changes on rising edge.
REQ-003 clear  input  1  reset, asynchronous and active-high.
REQ-004 req  input  25  per-source bus request; bit i corresponds to bus select code i (0-15 R0-R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 MAR, 23 Port, 24 C).
REQ-005 release  input  1  current owner finished; sampled only in GRANT.
REQ-006 grant  output  25  one-hot grant, registered; all zero when no owner.
REQ-007 bus_select  output  5  select code driven to the 32:1 bus multiplexer, registered.
REQ-008 bus_valid  output  1  high while a source owns the bus.
REQ-009 timeout  output  1  single-cycle pulse when an ownership is ended by the MAX_HOLD limit.

Function
REQ-010 FSM states: IDLE, GRANT; two states only.
REQ-011 IDLE: grant=0, bus_valid=0, bus_select=5'b11111 (unused code, multiplexer outputs zero).
REQ-012 IDLE with req!=0 at edge: next state GRANT; winner chosen round-robin; grant/bus_select/bus_valid valid from the following cycle (1-cycle request-to-grant latency).
REQ-013 Round-robin: search starts at last_owner+1, ascending, wraps from 24 to 0; first set req bit wins; last_owner updates to winner.
REQ-014 GRANT holds grant, bus_select=winner code, bus_valid=1 unchanged every cycle until an end condition.
REQ-015 End conditions, sampled at edge in GRANT: release=1, or req[owner]=0, or hold counter reaching MAX_HOLD; any one returns FSM to IDLE.
REQ-016 Hold counter: 8 bits, cleared on entry to GRANT, increments each GRANT cycle; ownership lasts exactly MAX_HOLD cycles when never released.
REQ-017 timeout pulses high for the first IDLE cycle after a MAX_HOLD-forced exit only; release and hold limit in the same cycle count as release (no pulse).
REQ-018 Every ownership is followed by exactly one IDLE turnaround cycle; grant never changes owner directly.
REQ-019 release or req changes while in IDLE: no effect apart from arbitration per REQ-012.
REQ-020 Single requester holding req continuously after timeout: regranted after the one-cycle turnaround.
REQ-021 grant is always zero or one-hot; grant[bus_select]=1 whenever bus_valid=1.

Reset
REQ-022 clear=1 asynchronously forces IDLE, grant=0, bus_select=5'b11111, bus_valid=0, timeout=0, hold counter=0, last_owner=24 (so the first search starts at code 0).
REQ-023 clear asserted mid-ownership drops the grant immediately, without waiting for a clock edge; the first arbitration after clear deasserts follows REQ-012.

Structure
REQ-024 Shared package bus_pkg holds the source select codes (0-24), IDLE_SEL=5'b11111, NUM_SRC=25.
REQ-025 One sub-module rr_picker: combinational; inputs req[24:0] and last_owner[4:0]; outputs winner[4:0] and any; no state.
REQ-026 All outputs are driven directly from registers; no combinational path from req or release to any output.

Verification
REQ-027 Reset, then req=bit 20 (PC) for 1 cycle -> next cycle grant=bit 20, bus_select=20, bus_valid=1.
REQ-028 req bits 3, 21 held, release pulsed each ownership, last_owner=24 -> owners 3, 21, 3, 21, with one IDLE cycle between each.
REQ-029 MAX_HOLD=4, req bit 24 held, no release -> bus_valid high 4 cycles, 1 IDLE cycle with timeout=1, then regrant to 24.
REQ-030 Owner 5, req[5] drops with release=0 -> IDLE next cycle, timeout=0, bus_select=31.
REQ-031 clear asserted between clock edges during ownership of 16 -> grant=0, bus_select=31 immediately; after clear deasserts, req bits 0 and 16 -> owner 0 first.
REQ-032 Random req/release for 10k cycles -> grant always zero or one-hot, matches bus_select, no ownership exceeds MAX_HOLD cycles, no starvation beyond 24 ownerships.
